soc_addr_decode_stage: RTL and testbench

Single-entry registered address-decode stage between the core-side memory request port and the SoC crossbar. Matches every incoming request address against the ten fixed SoC regions (Debug, ROM, CLINT, PLIC, UART, Timer, SPI, Ethernet, GPIO, DRAM), tags it with the target slave index and a cacheable flag, and forwards it. Unmapped addresses never reach the crossbar; the stage answers them itself with a decode-error response.

---
 rtl/soc_addr_decode_stage_if.sv | 38 +++
 rtl/soc_addr_decode_stage.sv | 140 ++++++++++++++
 tb/tb_soc_addr_decode_stage.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_addr_decode_stage_if.sv
// Request, crossbar and decode-error channels of soc_addr_decode_stage.
// master = request issuer / downstream consumer side, slave = the decode stage.
interface soc_addr_decode_stage_if #(
  parameter int IdWidth   = 4,
  parameter int AddrWidth = 64
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AddrWidth-1:0] req_addr_i;
  logic                 req_we_i;
  logic [IdWidth-1:0]   req_id_i;

  logic                 slv_valid_o;
  logic                 slv_ready_i;
  logic [AddrWidth-1:0] slv_addr_o;
  logic [3:0]           slv_idx_o;
  logic                 slv_we_o;
  logic [IdWidth-1:0]   slv_id_o;
  logic                 slv_cached_o;

  logic                 err_valid_o;
  logic                 err_ready_i;
  logic [IdWidth-1:0]   err_id_o;
  logic                 err_we_o;
  logic [15:0]          err_cnt_o;

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_id_i, slv_ready_i, err_ready_i,
    input  req_ready_o, slv_valid_o, slv_addr_o, slv_idx_o, slv_we_o, slv_id_o,
           slv_cached_o, err_valid_o, err_id_o, err_we_o, err_cnt_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_id_i, slv_ready_i, err_ready_i,
    output req_ready_o, slv_valid_o, slv_addr_o, slv_idx_o, slv_we_o, slv_id_o,
           slv_cached_o, err_valid_o, err_id_o, err_we_o, err_cnt_o
  );
endinterface

// File: rtl/soc_addr_decode_stage.sv
// Single-entry registered address decoder in front of the SoC crossbar; unmapped requests get a local error.
// Optional decode-error counter enabled by `SOC_DECODE_ERR_CNT_EN.
module soc_addr_decode_stage #(
  parameter int IdWidth   = 4,
  parameter int AddrWidth = 64
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  soc_addr_decode_stage_if.slave bus
);
  localparam int NumRegions = 10;

  typedef enum logic [1:0] {EMPTY, FWD, ERR} state_t;

  // Region tables indexed by slave index (DRAM=0 ... Debug=9).
  function automatic logic [AddrWidth:0] region_base(input int idx);
    case (idx)
      0:       return (AddrWidth+1)'(64'h8000_0000);
      1:       return (AddrWidth+1)'(64'h4000_0000);
      2:       return (AddrWidth+1)'(64'h3000_0000);
      3:       return (AddrWidth+1)'(64'h2000_0000);
      4:       return (AddrWidth+1)'(64'h1800_0000);
      5:       return (AddrWidth+1)'(64'h1000_0000);
      6:       return (AddrWidth+1)'(64'h0C00_0000);
      7:       return (AddrWidth+1)'(64'h0200_0000);
      8:       return (AddrWidth+1)'(64'h0001_0000);
      default: return '0;
    endcase
  endfunction

  function automatic logic [AddrWidth:0] region_len(input int idx);
    case (idx)
      0:       return (AddrWidth+1)'(64'h4000_0000);
      1:       return (AddrWidth+1)'(64'h0000_1000);
      2:       return (AddrWidth+1)'(64'h0001_0000);
      3:       return (AddrWidth+1)'(64'h0080_0000);
      4:       return (AddrWidth+1)'(64'h0000_1000);
      5:       return (AddrWidth+1)'(64'h0000_1000);
      6:       return (AddrWidth+1)'(64'h03FF_FFFF);
      7:       return (AddrWidth+1)'(64'h000C_0000);
      8:       return (AddrWidth+1)'(64'h0001_0000);
      default: return (AddrWidth+1)'(64'h0000_1000);
    endcase
  endfunction

  logic [NumRegions-1:0] hit;
  logic [3:0]            hit_idx;
  logic                  hit_any;

  // One extra bit: an address below base borrows into bit AddrWidth and can never
  // compare below a length, so base <= addr < base+len holds without any wrap.
  for (genvar gi = 0; gi < NumRegions; gi++) begin : g_region
    localparam logic [AddrWidth:0] Base = region_base(gi);
    localparam logic [AddrWidth:0] Len  = region_len(gi);
    logic [AddrWidth:0] offset;
    assign offset  = {1'b0, bus.req_addr_i} - Base;
    assign hit[gi] = (offset < Len);
  end

  always_comb begin
    hit_idx = '0;
    for (int i = NumRegions - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = 4'(i);
    end
  end

  assign hit_any = |hit;

  state_t               state_reg, state_next;
  logic                 req_ready, accept;
  logic [AddrWidth-1:0] addr_reg;
  logic [3:0]           idx_reg;
  logic                 we_reg;
  logic [IdWidth-1:0]   id_reg;
  logic                 cached_reg;

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    case (state_reg)
      EMPTY:   req_ready = 1'b1;
      FWD:     req_ready = bus.slv_ready_i;
      ERR:     req_ready = bus.err_ready_i;
      default: req_ready = 1'b0;
    endcase
    accept = bus.req_valid_i & req_ready;
    if (accept) begin
      state_next = hit_any ? FWD : ERR;
    end else if (state_reg != EMPTY && req_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg  <= EMPTY;
      addr_reg   <= '0;
      idx_reg    <= '0;
      we_reg     <= 1'b0;
      id_reg     <= '0;
      cached_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg   <= bus.req_addr_i;
        idx_reg    <= hit_idx;
        we_reg     <= bus.req_we_i;
        id_reg     <= bus.req_id_i;
        cached_reg <= hit_any && (hit_idx == 4'd0);
      end
    end
  end

`ifdef SOC_DECODE_ERR_CNT_EN
  logic [15:0] err_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_cnt_reg <= '0;
    end else if (accept && !hit_any && err_cnt_reg != 16'hFFFF) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign bus.err_cnt_o = err_cnt_reg;
`else
  assign bus.err_cnt_o = '0;
`endif

  assign bus.req_ready_o  = req_ready;
  assign bus.slv_valid_o  = (state_reg == FWD);
  assign bus.err_valid_o  = (state_reg == ERR);
  assign bus.slv_addr_o   = addr_reg;
  assign bus.slv_idx_o    = idx_reg;
  assign bus.slv_we_o     = we_reg;
  assign bus.slv_id_o     = id_reg;
  assign bus.slv_cached_o = cached_reg;
  assign bus.err_id_o     = id_reg;
  assign bus.err_we_o     = we_reg;
endmodule

// File: tb/tb_soc_addr_decode_stage.sv
// Scoreboard bench for soc_addr_decode_stage: randomized and directed requests checked against a region-table model.
// Counter expectations follow `SOC_DECODE_ERR_CNT_EN.
module tb_soc_addr_decode_stage;
  localparam int IdWidth   = 4;
  localparam int AddrWidth = 64;
`ifdef SOC_DECODE_ERR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  soc_addr_decode_stage_if #(.IdWidth(IdWidth), .AddrWidth(AddrWidth)) bus ();

  soc_addr_decode_stage #(.IdWidth(IdWidth), .AddrWidth(AddrWidth)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Region map by slave index: DRAM, GPIO, Ethernet, SPI, Timer, UART, PLIC, CLINT, ROM, Debug.
  logic [64:0] rg_base [10] = '{65'h8000_0000, 65'h4000_0000, 65'h3000_0000, 65'h2000_0000,
                                65'h1800_0000, 65'h1000_0000, 65'h0C00_0000, 65'h0200_0000,
                                65'h0001_0000, 65'h0};
  logic [64:0] rg_len  [10] = '{65'h4000_0000, 65'h1000, 65'h1_0000, 65'h80_0000,
                                65'h1000, 65'h1000, 65'h3FF_FFFF, 65'hC_0000,
                                65'h1_0000, 65'h1000};

  typedef struct {
    bit          err;
    logic [3:0]  idx;
    bit          cached;
    logic [63:0] addr;
    bit          we;
    logic [3:0]  id;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cnt_model = 0;
  int unsigned cyc = 0;
  bit          rdy_mode = 1'b0;
  bit          quiet = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input bit w, input logic [3:0] id);
    exp_t e;
    e.err = 1'b1; e.idx = 4'd0; e.cached = 1'b0; e.addr = a; e.we = w; e.id = id;
    for (int r = 0; r < 10; r++) begin
      if (e.err && {1'b0, a} >= rg_base[r] && {1'b0, a} < rg_base[r] + rg_len[r]) begin
        e.err = 1'b0;
        e.idx = 4'(r);
        e.cached = (r == 0);
      end
    end
    return e;
  endfunction

  // Monitor: inputs change just after posedge, so negedge sees what the next edge will use.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      cnt_model = 0;
    end else begin
      bit busy;
      bit exp_rdy;
      busy = (q.size() > 0);
      chk("occupancy", 64'(bus.slv_valid_o | bus.err_valid_o), 64'(busy));
      chk("exclusive_valid", 64'(bus.slv_valid_o & bus.err_valid_o), 64'd0);
      chk("err_cnt", 64'(bus.err_cnt_o), CntEn ? 64'(cnt_model) : 64'd0);
      exp_rdy = !busy || (q[0].err ? bus.err_ready_i : bus.slv_ready_i);
      chk("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
      if (busy) begin
        if (q[0].err) begin
          chk("err_valid", 64'(bus.err_valid_o), 64'd1);
          chk("err_id", 64'(bus.err_id_o), 64'(q[0].id));
          chk("err_we", 64'(bus.err_we_o), 64'(q[0].we));
        end else begin
          chk("slv_valid", 64'(bus.slv_valid_o), 64'd1);
          chk("slv_addr", bus.slv_addr_o, q[0].addr);
          chk("slv_idx", 64'(bus.slv_idx_o), 64'(q[0].idx));
          chk("slv_we", 64'(bus.slv_we_o), 64'(q[0].we));
          chk("slv_id", 64'(bus.slv_id_o), 64'(q[0].id));
          chk("slv_cached", 64'(bus.slv_cached_o), 64'(q[0].cached));
        end
        if (q[0].err ? bus.err_ready_i : bus.slv_ready_i) begin
          if (!quiet)
            $display("txn %s id=%0h we=%0d addr=%h idx=%0d", q[0].err ? "decode-err" : "forward",
                     q[0].id, q[0].we, q[0].addr, q[0].idx);
          void'(q.pop_front());
        end
      end
      if (bus.req_valid_i && bus.req_ready_o) begin
        exp_t e;
        e = model(bus.req_addr_i, bus.req_we_i, bus.req_id_i);
        if (e.err && cnt_model != 32'hFFFF) cnt_model++;
        q.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode) begin
      bus.slv_ready_i = ($urandom_range(0, 3) != 0);
      bus.err_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [63:0] a, input bit w, input logic [3:0] id);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_we_i    = w;
    bus.req_id_i    = id;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (bus.req_ready_o) break;
      if (t > 200) begin
        chk("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic send_expect(input logic [63:0] a, input logic [3:0] id, input bit exp_err,
                             input logic [3:0] exp_idx);
    send(a, 1'b0, id);
    @(negedge clk);
    chk("dir_err_valid", 64'(bus.err_valid_o), 64'(exp_err));
    chk("dir_slv_valid", 64'(bus.slv_valid_o), 64'(!exp_err));
    if (!exp_err) begin
      chk("dir_idx", 64'(bus.slv_idx_o), 64'(exp_idx));
      chk("dir_cached", 64'(bus.slv_cached_o), 64'(exp_idx == 4'd0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [63:0] dir_addr [16] = '{64'h1000_0004, 64'h8000_0000, 64'hBFFF_FFFF, 64'hC000_0000,
                                 64'h020B_FFFF, 64'h020C_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                                 64'h0001_FFFF, 64'h0C00_0000, 64'h0FFF_FFFE, 64'h0FFF_FFFF,
                                 64'h3000_FFFF, 64'h4000_0FFF, 64'h207F_FFFF, 64'h1800_0000};
  bit          dir_err  [16] = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  logic [3:0]  dir_idx  [16] = '{5, 0, 0, 0, 7, 0, 0, 9, 8, 6, 6, 0, 2, 1, 3, 4};

  function automatic logic [63:0] rand_addr();
    int r;
    logic [64:0] b;
    logic [64:0] l;
    r = $urandom_range(0, 9);
    b = rg_base[r];
    l = rg_len[r];
    case ($urandom_range(0, 3))
      0:       return 64'(b + (65'($urandom) % l));
      1:       return 64'(b + l);
      2:       return 64'(b + l - 65'd1);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_we_i    = 1'b0;
    bus.req_id_i    = '0;
    bus.slv_ready_i = 1'b1;
    bus.err_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_slv_valid", 64'(bus.slv_valid_o), 64'd0);
    chk("rst_err_valid", 64'(bus.err_valid_o), 64'd0);
    chk("rst_addr", bus.slv_addr_o, 64'd0);
    chk("rst_id", 64'(bus.slv_id_o), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    @(posedge clk);
    #1;

    // Directed region hits and boundaries (UART id 3 first).
    for (int i = 0; i < 16; i++) send_expect(dir_addr[i], (i == 0) ? 4'd3 : 4'(i), dir_err[i], dir_idx[i]);

    // Back-to-back: four accepts on four consecutive edges.
    begin
      int unsigned c0;
      c0 = cyc;
      for (int i = 0; i < 4; i++) send(64'h8000_0100 + 64'(i * 8), 1'b1, 4'(i));
      chk("b2b_cycles", 64'(cyc - c0), 64'd4);
    end

    // Stall: hold the crossbar off for 3 cycles while a second request waits.
    @(posedge clk);
    #1;
    bus.slv_ready_i = 1'b0;
    send(64'h1000_0010, 1'b0, 4'hA);
    fork
      send(64'h4000_0020, 1'b1, 4'hB);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.slv_ready_i = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Three decode errors, each answered two cycles late.
    do_reset();
    bus.err_ready_i = 1'b0;
    fork
      for (int i = 0; i < 3; i++) send(64'hC000_0000 + 64'(i), 1'(i), 4'(4 + i));
      for (int k = 0; k < 3; k++) begin
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          if (bus.err_valid_o) break;
        end
        repeat (2) @(posedge clk);
        #1;
        bus.err_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.err_ready_i = 1'b0;
      end
    join
    @(negedge clk);
    chk("err_cnt_after3", 64'(bus.err_cnt_o), CntEn ? 64'd3 : 64'd0);
    @(posedge clk);
    #1;
    bus.err_ready_i = 1'b1;

    // Reset while a forwarded request is stalled.
    bus.slv_ready_i = 1'b0;
    send(64'h2000_0000, 1'b0, 4'h7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_slv_valid", 64'(bus.slv_valid_o), 64'd0);
    chk("midrst_err_cnt", 64'(bus.err_cnt_o), 64'd0);
    chk("midrst_req_ready", 64'(bus.req_ready_o), 64'd1);
    @(posedge clk);
    #1;
    bus.slv_ready_i = 1'b1;

    // Randomized traffic with random backpressure.
    rdy_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if (bus.req_valid_i == 1'b0) begin
        @(posedge clk);
        #1;
      end
      send(rand_addr(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    rdy_mode = 1'b0;
    @(posedge clk);
    #2;
    bus.slv_ready_i = 1'b1;
    bus.err_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drained", 64'(q.size()), 64'd0);

`ifdef SOC_DECODE_ERR_CNT_EN
    // Saturation: enough back-to-back decode errors to pass 0xFFFF.
    do_reset();
    quiet = 1'b1;
    for (int i = 0; i < 65540; i++) send(64'hFFFF_0000_0000_0000, 1'b0, 4'(i));
    @(negedge clk);
    chk("err_cnt_saturated", 64'(bus.err_cnt_o), 64'hFFFF);
    quiet = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
